// File: rtl/mvau_wmem_addr_gen.sv
// Weight-memory address generator for the MVAU: walks SF*NF weight tiles per
// accepted activation vector, NUM_VEC vectors per start, 1-cycle aligned valid/last stream.
module mvau_wmem_addr_gen #(
    parameter int SF           = 4,
    parameter int NF           = 2,
    parameter int NUM_VEC      = 16,
    parameter int WMEM_ADDR_BW = (SF * NF > 1) ? $clog2(SF * NF) : 1,
    parameter int VEC_BW       = $clog2(NUM_VEC + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clr,
    input  logic                    step_v,
    output logic                    step_rdy,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    wmem_ren,
    output logic                    wgt_v,
    input  logic                    out_rdy,
    output logic                    sf_last,
    output logic                    nf_last,
    output logic [VEC_BW-1:0]       vec_cnt,
    output logic                    busy,
    output logic                    done
);

    localparam int SF_BW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_BW-1:0]        SF_MAX   = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_MAX   = NF_BW'(NF - 1);
    localparam logic [WMEM_ADDR_BW-1:0] ADDR_MAX = WMEM_ADDR_BW'(SF * NF - 1);
    localparam logic [VEC_BW-1:0]       VEC_MAX  = VEC_BW'(NUM_VEC);
    localparam logic [VEC_BW-1:0]       VEC_LAST = VEC_BW'(NUM_VEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [SF_BW-1:0] sf_cnt;
    logic [NF_BW-1:0] nf_cnt;
    logic             issue;
    logic             sf_wrap;
    logic             nf_wrap;
    logic             vec_end;

    // A stalled output stage blocks issue so the BRAM output register stays stable.
    assign step_rdy = (state == RUN) && (!wgt_v || out_rdy) && !clr;
    assign issue    = step_v && step_rdy;
    assign wmem_ren = issue;
    assign busy     = (state != IDLE);
    assign sf_wrap  = (sf_cnt == SF_MAX);
    assign nf_wrap  = (nf_cnt == NF_MAX);
    assign vec_end  = sf_wrap && nf_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wmem_addr <= '0;
            sf_cnt    <= '0;
            nf_cnt    <= '0;
            vec_cnt   <= '0;
            wgt_v     <= 1'b0;
            sf_last   <= 1'b0;
            nf_last   <= 1'b0;
            done      <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            wmem_addr <= '0;
            sf_cnt    <= '0;
            nf_cnt    <= '0;
            vec_cnt   <= '0;
            wgt_v     <= 1'b0;
            sf_last   <= 1'b0;
            nf_last   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        wmem_addr <= '0;
                        sf_cnt    <= '0;
                        nf_cnt    <= '0;
                        vec_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (issue && vec_end && vec_cnt == VEC_LAST)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!wgt_v || out_rdy) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                wmem_addr <= (wmem_addr == ADDR_MAX) ? '0 : wmem_addr + 1'b1;
                sf_cnt    <= sf_wrap ? '0 : sf_cnt + 1'b1;
                if (sf_wrap)
                    nf_cnt <= nf_wrap ? '0 : nf_cnt + 1'b1;
                if (vec_end && vec_cnt != VEC_MAX)
                    vec_cnt <= vec_cnt + 1'b1;
                wgt_v   <= 1'b1;
                sf_last <= sf_wrap;
                nf_last <= nf_wrap;
            end else if (out_rdy) begin
                wgt_v <= 1'b0;
            end
        end
    end

endmodule
